// File: rtl/bram_std_fifo_stream_out.sv
// Read-side adapter: turns the standard (one-cycle latency) FIFO read port into a
// valid/ready stream through a 2-entry output buffer, one word per cycle at full rate.
module bram_std_fifo_stream_out #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic [DATA_WIDTH-1:0] dest_tdata,
  output logic                  dest_tvalid,
  input  logic                  dest_tready
);

  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;

  logic       pop;
  logic [2:0] level;
  logic [1:0] wr_idx;

  assign dest_tvalid = (occ_q != 2'd0);
  assign dest_tdata  = buf0_q;
  assign pop         = dest_tvalid && dest_tready;

  // Occupancy after this edge, counting the word already on its way from the FIFO.
  // Sampling pop here keeps reads flowing while the consumer drains the head.
  assign level      = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign fifo_rd_en = !rst && !fifo_empty && (level < 3'd2);

  // Slot that receives the arriving word, after the head has shifted out.
  assign wr_idx = occ_q - {1'b0, pop};

  always_comb begin
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    occ_d      = level[1:0];
    inflight_d = fifo_rd_en;
    if (pop) begin
      buf0_d = buf1_q;
    end
    if (inflight_q) begin
      if (wr_idx == 2'd0) begin
        buf0_d = fifo_data;
      end else begin
        buf1_d = fifo_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      buf0_q     <= '0;
      buf1_q     <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
    end
  end

endmodule

// File: tb/tb_bram_std_fifo_stream_out.sv
// Bench for bram_std_fifo_stream_out: a queue-based FIFO source and output-buffer
// model predict the stream cycle by cycle; delivered sequences are checked in order.
module tb_bram_std_fifo_stream_out;

  logic       clk = 1'b0;
  logic       rst;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic [7:0] fifo_data;
  logic [7:0] dest_tdata;
  logic       dest_tvalid;
  logic       dest_tready;

  bram_std_fifo_stream_out #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_data  (fifo_data),
    .dest_tdata (dest_tdata),
    .dest_tvalid(dest_tvalid),
    .dest_tready(dest_tready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [7:0] src_q[$];    // words the FIFO still holds
  logic [7:0] out_q[$];    // words the adapter should be holding
  logic [7:0] recv_q[$];   // words the DUT actually delivered
  logic [7:0] exp_q[$];    // expected delivery sequence for a test
  bit         inflight_m;
  logic [7:0] pending_m;
  bit         gate_empty;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_empty();
    fifo_empty = gate_empty || (src_q.size() == 0);
  endtask

  task automatic cycle(input bit chk_zero = 1'b0);
    int         lvl;
    bit         pop_m;
    bit         rd_m;
    logic [7:0] seen;
    @(negedge clk);
    pop_m = (out_q.size() != 0) && dest_tready;
    lvl   = out_q.size() + int'(inflight_m) - int'(pop_m);
    rd_m  = !rst && !fifo_empty && (lvl < 2);
    seen  = dest_tdata;
    chk("rd_en", {31'd0, fifo_rd_en}, {31'd0, rd_m});
    chk("tvalid", {31'd0, dest_tvalid}, {31'd0, out_q.size() != 0});
    if (out_q.size() != 0) chk("tdata", {24'd0, dest_tdata}, {24'd0, out_q[0]});
    if (chk_zero) chk("tdata_rst", {24'd0, dest_tdata}, 32'd0);
    @(posedge clk);
    #1;
    if (rst) begin
      out_q.delete();
      inflight_m = 1'b0;
    end else begin
      if (pop_m) begin
        void'(out_q.pop_front());
        recv_q.push_back(seen);
      end
      if (inflight_m) out_q.push_back(pending_m);
      inflight_m = rd_m;
      if (rd_m) begin
        pending_m = src_q.pop_front();
        fifo_data = pending_m;
      end
    end
    set_empty();
  endtask

  task automatic chk_seq(input string tag);
    chk({tag, "_count"}, recv_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < recv_q.size(); i++)
      chk(tag, {24'd0, recv_q[i]}, {24'd0, exp_q[i]});
    recv_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] first_after_rst;
    logic [7:0] w;
    rst         = 1'b1;
    dest_tready = 1'b1;
    fifo_data   = 8'h00;
    gate_empty  = 1'b0;
    inflight_m  = 1'b0;
    pending_m   = 8'h00;
    src_q.push_back(8'hA5);
    set_empty();
    @(posedge clk);
    #1;

    // reset held with a non-empty FIFO
    repeat (2) cycle(1'b1);
    rst = 1'b0;

    // single word
    exp_q.push_back(8'hA5);
    repeat (6) cycle();
    chk_seq("single");

    // continuous streaming
    for (int i = 1; i <= 16; i++) begin
      w = 8'(i);
      src_q.push_back(w);
      exp_q.push_back(w);
    end
    set_empty();
    repeat (20) cycle();
    chk_seq("stream");

    // backpressure mid-stream
    for (int i = 0; i < 32; i++) begin
      w = 8'(8'h20 + i);
      src_q.push_back(w);
      exp_q.push_back(w);
    end
    set_empty();
    repeat (6) cycle();
    dest_tready = 1'b0;
    repeat (5) cycle();
    dest_tready = 1'b1;
    repeat (34) cycle();
    chk_seq("backpressure");

    // bursty source
    for (int i = 0; i < 16; i++) begin
      w = 8'(8'h10 + i);
      src_q.push_back(w);
      exp_q.push_back(w);
    end
    for (int i = 0; i < 72; i++) begin
      gate_empty = ((i / 3) % 2) == 1;
      set_empty();
      cycle();
    end
    gate_empty = 1'b0;
    set_empty();
    repeat (4) cycle();
    chk_seq("bursty");

    // random source gating and consumer backpressure
    for (int i = 0; i < 40; i++) begin
      w = 8'($urandom);
      src_q.push_back(w);
      exp_q.push_back(w);
    end
    for (int i = 0; i < 200; i++) begin
      dest_tready = ($urandom_range(0, 99) < 60);
      gate_empty  = ($urandom_range(0, 99) < 30);
      set_empty();
      cycle();
    end
    dest_tready = 1'b1;
    gate_empty  = 1'b0;
    set_empty();
    repeat (10) cycle();
    chk_seq("random");

    // reset with a full output buffer
    for (int i = 0; i < 8; i++) src_q.push_back(8'(8'h80 + i));
    set_empty();
    dest_tready = 1'b0;
    repeat (4) cycle();
    chk("full_before_rst", out_q.size(), 2);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    first_after_rst = src_q[0];
    for (int i = 0; i < src_q.size(); i++) exp_q.push_back(src_q[i]);
    dest_tready = 1'b1;
    repeat (10) cycle();
    chk("first_after_rst", (recv_q.size() != 0) ? {24'd0, recv_q[0]} : 32'hFFFF_FFFF,
        {24'd0, first_after_rst});
    chk_seq("after_rst");

    // reset with one word buffered and one in flight
    for (int i = 0; i < 6; i++) src_q.push_back(8'(8'hC0 + i));
    set_empty();
    dest_tready = 1'b0;
    cycle();
    cycle();
    chk("mid_occ", out_q.size() + int'(inflight_m), 2);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < src_q.size(); i++) exp_q.push_back(src_q[i]);
    dest_tready = 1'b1;
    repeat (10) cycle();
    chk_seq("after_rst2");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
